// File: rtl/mux41_scan_ctrl_pkg.sv
// Shared constants and state encoding for the 4:1 mux select sequencer.
package mux41_scan_ctrl_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef logic [CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/mux41_scan_ctrl_rr_pick4.sv
// Combinational round-robin pick over four requesters, starting after 'last'.
module rr_pick4
  import mux41_scan_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           last,
  output ch_idx_t           idx,
  output logic              any
);

  ch_idx_t cand;

  // Walk offsets farthest-first so the nearest requester after 'last' wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = last + CH_W'(off);
      if (req[cand]) idx = cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux41_scan_ctrl.sv
// Round-robin select sequencer: holds each granted mux channel for DWELL cycles.
module mux41_scan_ctrl
  import mux41_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  output logic              s0,
  output logic              s1,
  output logic              valid,
  output logic              ch_done,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DWELL - 1);
  localparam logic             LOAD_DONE = (DWELL == 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  ch_idx_t          last_q;
  ch_idx_t          sel_q;
  logic             valid_q;
  logic             done_q;

  ch_idx_t          pick_last;
  ch_idx_t          pick_idx;
  logic             pick_any;

  // At the end of a grant the pointer moves to the current channel in the
  // same edge as the next pick, so the picker already sees it as 'last'.
  assign pick_last = (state_q == ST_HOLD && cnt_q == '0) ? sel_q : last_q;

  rr_pick4 u_pick (
    .req  (req),
    .last (pick_last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= ch_idx_t'(NUM_CH - 1);
      sel_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (en && pick_any) begin
            state_q <= ST_HOLD;
            sel_q   <= pick_idx;
            cnt_q   <= CNT_LOAD;
            valid_q <= 1'b1;
            done_q  <= LOAD_DONE;
          end else begin
            valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            last_q <= sel_q;
            if (en && pick_any) begin
              sel_q   <= pick_idx;
              cnt_q   <= CNT_LOAD;
              valid_q <= 1'b1;
              done_q  <= LOAD_DONE;
            end else begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b0;
            end
          end else if (!en) begin
            // Abort: pointer untouched so the dropped channel keeps priority.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == CNT_W'(1));
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s0      = sel_q[0];
  assign s1      = sel_q[1];
  assign valid   = valid_q;
  assign ch_done = done_q;
  assign busy    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Bench for mux41_scan_ctrl: DWELL=4 and DWELL=1 instances against a grant-level model.
module tb_mux41_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [1:0] s0, s1, vld, dn, bsy;
  logic [7:0] d [4];
  logic [7:0] y [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux41_scan_ctrl #(.DWELL(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .s0(s0[0]), .s1(s1[0]), .valid(vld[0]), .ch_done(dn[0]), .busy(bsy[0]));

  mux41_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .s0(s0[1]), .s1(s1[1]), .valid(vld[1]), .ch_done(dn[1]), .busy(bsy[1]));

  // Behavioural stand-in for the downstream 4:1 mux.
  always_comb begin
    y[0] = d[{s1[0], s0[0]}];
    y[1] = d[{s1[1], s0[1]}];
  end

  // Model: one active grant record per instance (channel, cycles still to hold).
  int dw     [2] = '{4, 1};
  bit m_act  [2];
  int m_ch   [2];
  int m_rem  [2];
  int m_last [2];

  function automatic int rr_next(int last, logic [3:0] r);
    for (int off = 1; off <= 4; off++)
      if (r[(last + off) % 4]) return (last + off) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_ch[i] = 0; m_rem[i] = 0; m_last[i] = 3;
    end
  endtask

  task automatic model_edge(logic e, logic [3:0] r);
    for (int i = 0; i < 2; i++) begin
      if (m_act[i] && m_rem[i] > 0) begin
        if (!e) m_act[i] = 0;
        else    m_rem[i]--;
      end else begin
        if (m_act[i]) m_last[i] = m_ch[i];
        if (e && r != 4'b0) begin
          m_act[i] = 1;
          m_ch[i]  = rr_next(m_last[i], r);
          m_rem[i] = dw[i] - 1;
        end else begin
          m_act[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sel%0d", i),   {30'd0, s1[i], s0[i]}, m_ch[i]);
      chk($sformatf("valid%0d", i), {31'd0, vld[i]}, {31'd0, m_act[i]});
      chk($sformatf("done%0d", i),  {31'd0, dn[i]},  {31'd0, (m_act[i] && m_rem[i] == 0)});
      chk($sformatf("busy%0d", i),  {31'd0, bsy[i]}, {31'd0, m_act[i]});
      if (m_act[i]) chk($sformatf("y%0d", i), {24'd0, y[i]}, {24'd0, d[m_ch[i]]});
    end
  endtask

  // One clock: apply inputs, advance model on the edge, compare 1ns later.
  task automatic cyc(logic e, logic [3:0] r);
    en = e; req = r;
    for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
    @(posedge clk);
    if (rst_n) model_edge(e, r);
    #1;
    check_all();
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ares_s0_%0d", i),    {31'd0, s0[i]},  32'd0);
      chk($sformatf("ares_s1_%0d", i),    {31'd0, s1[i]},  32'd0);
      chk($sformatf("ares_valid_%0d", i), {31'd0, vld[i]}, 32'd0);
      chk($sformatf("ares_done_%0d", i),  {31'd0, dn[i]},  32'd0);
      chk($sformatf("ares_busy_%0d", i),  {31'd0, bsy[i]}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 4'b1111;
    for (int k = 0; k < 4; k++) d[k] = 8'(k);
    model_reset();
    repeat (3) cyc(1'b1, 4'b1111);
    rst_n = 1'b1;

    // Full request set: 0,1,2,3,0 each held DWELL cycles.
    for (int c = 1; c <= 20; c++) begin
      cyc(1'b1, 4'b1111);
      chk("t2_sel", {30'd0, s1[0], s0[0]}, ((c - 1) / 4) % 4);
      chk("t2_done", {31'd0, dn[0]}, {31'd0, (c % 4 == 0)});
      chk("t2_valid", {31'd0, vld[0]}, 32'd1);
    end
    repeat (2) cyc(1'b0, 4'b0000);

    // Sole requester ch2 re-granted back-to-back.
    for (int c = 1; c <= 12; c++) begin
      cyc(1'b1, 4'b0100);
      chk("t3_sel", {30'd0, s1[0], s0[0]}, 32'd2);
      chk("t3_done", {31'd0, dn[0]}, {31'd0, (c % 4 == 0)});
    end
    cyc(1'b0, 4'b0000);

    // Park the pointer on ch0, then abort a ch1 grant mid-dwell.
    for (int c = 0; c < 8 && !(m_act[0] && m_rem[0] == 0); c++) cyc(1'b1, 4'b0001);
    chk("t4_park", m_rem[0], 32'd0);
    cyc(1'b0, 4'b0000);
    cyc(1'b1, 4'b0010);
    cyc(1'b1, 4'b0010);
    chk("t4_granted", {30'd0, s1[0], s0[0]}, 32'd1);
    cyc(1'b0, 4'b0010);
    chk("t4_abort_valid", {31'd0, vld[0]}, 32'd0);
    chk("t4_abort_done", {31'd0, dn[0]}, 32'd0);
    cyc(1'b0, 4'b0000);
    cyc(1'b1, 4'b0011);
    chk("t4_keep_prio", {30'd0, s1[0], s0[0]}, 32'd1);
    chk("t4_valid", {31'd0, vld[0]}, 32'd1);

    // DWELL=1: alternate ch1/ch3 every cycle with ch_done held.
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 4'b1010);
      chk("t5_done", {31'd0, dn[1]}, 32'd1);
      if (c > 0) chk("t5_sel_alt", {30'd0, s1[1], s0[1]}, (m_ch[1] == 1) ? 32'd1 : 32'd3);
    end
    cyc(1'b0, 4'b0000);

    // Async reset mid-HOLD on ch3, then ch0 wins first.
    cyc(1'b1, 4'b1000);
    cyc(1'b1, 4'b1000);
    chk("t6_ch3", {30'd0, s1[0], s0[0]}, 32'd3);
    async_reset_check();
    cyc(1'b1, 4'b1001);
    #2 rst_n = 1'b1;
    cyc(1'b1, 4'b1001);
    chk("t6_ch0_first", {30'd0, s1[0], s0[0]}, 32'd0);

    // Randomised traffic with occasional reset pulses.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset_check();
        cyc(1'b0, 4'b0000);
        #2 rst_n = 1'b1;
      end
      cyc(($urandom_range(0, 9) != 0), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
